// File: rtl/serial_detector_scheduler_pkg.sv
// rtl/serial_detector_scheduler_pkg.sv - shared types and constants for the serial detector scheduler
//
// Purpose: FSM state encoding, default word width and requester id constants.
// Ports:   none (package).
package serial_sched_pkg;

  localparam int DEF_W = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_detector_scheduler_if.sv
// rtl/serial_detector_scheduler_if.sv - request/response/detector bundle for the serial detector scheduler
//
// Purpose: groups the two requester ports, the response port, the detector
//          link and the busy flag.
// Modports:
//   slave  - the scheduler block (accepts requests, drives response/detector).
//   master - the surrounding logic (requesters, consumer, detector instance).
interface serial_detector_scheduler_if
  import serial_sched_pkg::*;
#(
  parameter int W = DEF_W
);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id;
  logic         det_clear;
  logic         det_x;
  logic         det_y;
  logic         busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready, det_y,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, det_clear, det_x, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready, det_y,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, det_clear, det_x, busy
  );

endinterface

// File: rtl/serial_detector_scheduler_rr_arb2.sv
// rtl/serial_detector_scheduler_rr_arb2.sv - two-way round-robin grant logic
//
// Purpose: picks one of two valid requesters; on a tie the one that was not
//          granted last wins. Purely combinational; the caller owns last_grant.
// Ports:
//   valid0, valid1 - requester valids
//   last_grant     - id granted on the previous accepted job
//   enable         - readies are only raised when enable is high
//   grant          - winning requester id
//   ready0, ready1 - one-hot ready for the winner (all zero when disabled)
module rr_arb2
  import serial_sched_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic grant,
  output logic ready0,
  output logic ready1
);

  assign grant  = (valid0 && valid1) ? ~last_grant : valid1;
  assign ready0 = enable && valid0 && (grant == REQ0);
  assign ready1 = enable && valid1 && (grant == REQ1);

endmodule

// File: rtl/serial_detector_scheduler.sv
// rtl/serial_detector_scheduler.sv - time-shares one serial Mealy detector between two requesters
//
// Purpose: arbitrates between two word requesters, restarts the detector,
//          shifts the word in LSB-first, collects the per-bit detector output
//          and returns it tagged with the requester id.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of serial_detector_scheduler_if (requests, response,
//           detector link, busy)
module serial_detector_scheduler
  import serial_sched_pkg::*;
#(
  parameter int W = DEF_W
)(
  input logic                        clock,
  input logic                        reset,
  serial_detector_scheduler_if.slave bus
);

  localparam int             CW   = $clog2(W) + 1;
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_t        state, state_next;
  logic [W-1:0]  shift_q;
  logic [W-1:0]  result_q;
  logic [CW-1:0] cnt_q;
  logic          id_q;
  logic          last_grant_q;

  logic          grant, ready0, ready1, accept, arb_en;

  // Gating with reset keeps the readies low while reset is held.
  assign arb_en = (state == IDLE) && reset;
  assign accept = ready0 | ready1;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant),
    .ready0     (ready0),
    .ready1     (ready1)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CLEAR;
      CLEAR:   state_next = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_next = DONE;
      DONE:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.det_clear = 1'b0;
    bus.det_x     = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      CLEAR:   bus.det_clear = 1'b1;
      SHIFT:   bus.det_x     = shift_q[0];
      DONE:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_data   = result_q;
  assign bus.rsp_id     = id_q;

  // Result fills from the top so that after W shifts the first detector
  // output lands in bit 0, matching input bit 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= REQ1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_q      <= grant ? bus.req1_data : bus.req0_data;
            id_q         <= grant;
            last_grant_q <= grant;
          end
        end
        CLEAR: cnt_q <= '0;
        SHIFT: begin
          result_q <= {bus.det_y, result_q[W-1:1]};
          shift_q  <= shift_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_detector_scheduler.md
Name: serial_detector_scheduler

Overview:
- Shares one serial bit-stream detector FSM (1-bit Mealy input/output) between two requesters.
- Each requester hands over a W-bit word. The block arbitrates round-robin, restarts the detector, and shifts the word in LSB-first, one bit per clock.
- It captures the detector's per-bit output into a W-bit result and returns it, tagged with the requester id, over a valid/ready response port.
- Sits between the requester logic and the detector instance in the sequence-detection datapath.

Parameters:
- W, 8, word width in bits (legal range 2..32); also the number of SHIFT cycles per job.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_ready  output  1  block accepts requester 0 this cycle.
- req0_data  input  W  requester 0 word.
- req1_valid  input  1  requester 1 has a word.
- req1_ready  output  1  block accepts requester 1 this cycle.
- req1_data  input  W  requester 1 word.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  W  detector outputs; bit i corresponds to input bit i.
- rsp_id  output  1  requester that owns rsp_data.
- det_clear  output  1  synchronous restart of the detector to its initial state.
- det_x  output  1  serial bit to the detector.
- det_y  input  1  detector Mealy output, combinational in det_x.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low; clock is `clock`. While reset is low:
  - state=IDLE, all outputs 0, shift/result/count registers 0.
  - last_grant=1, so requester 0 wins the first tie.
- State machine has four states: IDLE, CLEAR, SHIFT, DONE. Encoding lives in the package.
- IDLE:
  - grant = the only valid requester. If both are valid, grant goes to the requester that is not last_grant.
  - reqN_ready is high only for the granted requester, combinationally, and only in IDLE.
  - On valid&ready at an edge: latch data into the shift register, latch id, set last_grant=id, go to CLEAR.
- CLEAR (exactly 1 cycle): det_clear=1, det_x=0. Next state is SHIFT with cnt=0.
- SHIFT (exactly W cycles):
  - det_x = shift[0], det_clear=0.
  - At each edge: result[cnt] <= det_y; shift register shifts right; cnt increments.
  - After the edge where cnt==W-1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are registered and stable.
  - det_x=0, det_clear=0.
  - Hold indefinitely until rsp_ready. On rsp_valid&rsp_ready go to IDLE.
- Latency: accept edge T → det_clear high in cycle T+1 → SHIFT cycles T+2..T+W+1 → rsp_valid high from cycle T+W+2 (W+2 cycles; 10 for W=8).
- Throughput: no acceptance in DONE, so at least one IDLE cycle between jobs. Peak is one job per W+3 cycles.
- Requests arriving while busy are not accepted. The requester must hold valid and data stable until ready.
- Reset asserted mid-operation: the job is aborted, no response is produced, last_grant returns to 1.
- reqN_data is sampled only at the accept edge; later changes have no effect.
- cnt width is clog2(W)+1; it never wraps inside a job.

Decomposition:
- Package serial_sched_pkg holds:
  - state localparams (IDLE, CLEAR, SHIFT, DONE);
  - default W;
  - requester id constants REQ0=0, REQ1=1.
- One natural sub-module: rr_arb2. It takes two valids, last_grant and an enable, and produces grant id plus one-hot ready. It is purely combinational; the parent owns the last_grant register.

Test Plan:
- Bench detector models:
  - echo model: det_y=det_x;
  - inverting model: det_y=~det_x.
- 1. Release reset; req0_data=8'hA5, echo model → rsp_data=8'hA5, rsp_id=0, rsp_valid exactly 10 cycles after the accept edge, det_clear high exactly one cycle.
- 2. After reset, both valid (req0=8'h3C, req1=8'hC3) → req0 served first (rsp 3C, id 0), then req1 (rsp C3, id 1).
- 3. Inverting model, req1_data=8'h0F → rsp_data=8'hF0, rsp_id=1.
- 4. rsp_ready held low 5 cycles in DONE with req0 valid → rsp_data, rsp_id and rsp_valid stable, req0_ready stays 0, busy=1; after rsp_ready, req0 accepted within 2 cycles.
- 5. Assert reset at the 4th SHIFT cycle → all outputs 0 immediately, no response emitted; next request 8'h81 completes normally with rsp 8'h81.
- 6. Both requesters continuously valid for 4 jobs → grant order 0,1,0,1; with only req0 valid, req0 is served on every job.
